// File: rtl/day1_calorie_max.sv
`default_nettype none
// ============================================================================
//  Module   : day1_calorie_max
//  Purpose  : Streaming maximum-group-sum tracker. Consumes one 16-bit unsigned
//             value per rising edge of next_val. A zero value closes the open
//             group. The largest closed-group sum and the 1-based index of the
//             group that produced it are kept in output registers.
//  Ports    :
//    clk                in   1   system clock, rising-edge active
//    rst_n              in   1   asynchronous active-low reset
//    par_input          in  16   value to consume (0 = group terminator)
//    next_val           in   1   consume strobe, only its rising edge counts
//    highest_val_index  out  8   index of the group holding the maximum sum
//    highest_val_sum    out 16   largest closed-group sum
//  Revision : 1.0  initial release
// ============================================================================
module day1_calorie_max (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] par_input,
  input  logic        next_val,
  output logic [7:0]  highest_val_index,
  output logic [15:0] highest_val_sum
);

  localparam logic [15:0] c_SUM_MAX  = 16'hFFFF;
  localparam logic [7:0]  c_IDX_MAX  = 8'd255;
  localparam logic [7:0]  c_IDX_INIT = 8'd1;

  logic        next_val_q;
  logic [15:0] run_sum_q, run_sum_d;
  logic [7:0]  grp_idx_q, grp_idx_d;
  logic [15:0] hi_sum_q,  hi_sum_d;
  logic [7:0]  hi_idx_q,  hi_idx_d;

  logic        w_stb;
  logic [16:0] w_sum_ext;

  // Edge detect: a held next_val yields a single strobe. next_val_q resets
  // to 0, so next_val already high at reset release counts as an edge.
  assign w_stb     = next_val & ~next_val_q;
  // One extra bit catches overflow so the running sum can clamp.
  assign w_sum_ext = {1'b0, run_sum_q} + {1'b0, par_input};

  always_comb begin
    run_sum_d = run_sum_q;
    grp_idx_d = grp_idx_q;
    hi_sum_d  = hi_sum_q;
    hi_idx_d  = hi_idx_q;
    if (w_stb) begin
      if (par_input != 16'd0) begin
        run_sum_d = w_sum_ext[16] ? c_SUM_MAX : w_sum_ext[15:0];
      end else begin
        // Strictly greater: a tie keeps the earlier group, and an empty
        // group (sum 0) can never displace anything.
        if (run_sum_q > hi_sum_q) begin
          hi_sum_d = run_sum_q;
          hi_idx_d = grp_idx_q;
        end
        run_sum_d = 16'd0;
        grp_idx_d = (grp_idx_q == c_IDX_MAX) ? grp_idx_q : grp_idx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_val_q <= 1'b0;
      run_sum_q  <= 16'd0;
      grp_idx_q  <= c_IDX_INIT;
      hi_sum_q   <= 16'd0;
      hi_idx_q   <= 8'd0;
    end else begin
      next_val_q <= next_val;
      run_sum_q  <= run_sum_d;
      grp_idx_q  <= grp_idx_d;
      hi_sum_q   <= hi_sum_d;
      hi_idx_q   <= hi_idx_d;
    end
  end

  assign highest_val_sum   = hi_sum_q;
  assign highest_val_index = hi_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_day1_calorie_max.sv
`default_nettype none
// ============================================================================
//  Module   : tb_day1_calorie_max
//  Purpose  : Self-checking bench for day1_calorie_max. The driver issues
//             values, updates a list-of-groups reference model and queues the
//             expected outputs. An independent monitor watches for strobes and
//             compares the DUT outputs one clock later.
//  Revision : 1.0  initial release
// ============================================================================
module tb_day1_calorie_max;

  logic        clk;
  logic        rst_n;
  logic [15:0] par_input;
  logic        next_val;
  logic [7:0]  highest_val_index;
  logic [15:0] highest_val_sum;

  day1_calorie_max dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .par_input         (par_input),
    .next_val          (next_val),
    .highest_val_index (highest_val_index),
    .highest_val_sum   (highest_val_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Closed groups are kept as a plain list; the maximum is recomputed from
  // the whole list after each close.
  int cur_sum;
  int closed_sums[$];
  int best_sum;
  int best_idx;
  logic [23:0] exp_q[$];

  function automatic void model_reset();
    cur_sum = 0;
    closed_sums.delete();
    best_sum = 0;
    best_idx = 0;
  endfunction

  function automatic void model_value(input int v);
    if (v != 0) begin
      cur_sum = (cur_sum + v > 65535) ? 65535 : cur_sum + v;
    end else begin
      closed_sums.push_back(cur_sum);
      cur_sum  = 0;
      best_sum = 0;
      best_idx = 0;
      for (int k = 0; k < closed_sums.size(); k++) begin
        if (closed_sums[k] > best_sum) begin
          best_sum = closed_sums[k];
          best_idx = (k + 1 > 255) ? 255 : k + 1;
        end
      end
    end
  endfunction

  function automatic void push_expected();
    logic [15:0] s;
    logic [7:0]  i;
    s = best_sum[15:0];
    i = best_idx[7:0];
    exp_q.push_back({s, i});
  endfunction

  // ---------------- monitor ----------------
  logic mon_prev;
  logic mon_stb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_prev <= 1'b0;
      mon_stb  <= 1'b0;
    end else begin
      mon_stb  <= next_val & ~mon_prev;
      mon_prev <= next_val;
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_stb) begin
      logic [23:0] e;
      n_tests += 2;
      if (exp_q.size() == 0) begin
        n_fail += 2;
        $display("FAIL scoreboard_empty: DUT strobe with no expected entry, sum=%h idx=%0d",
                 highest_val_sum, highest_val_index);
      end else begin
        e = exp_q.pop_front();
        if (highest_val_sum !== e[23:8]) begin
          n_fail++;
          $display("FAIL sum: got %h expected %h at %0t", highest_val_sum, e[23:8], $time);
        end
        if (highest_val_index !== e[7:0]) begin
          n_fail++;
          $display("FAIL index: got %0d expected %0d at %0t", highest_val_index, e[7:0], $time);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left on a falling edge with next_val low.
  task automatic send(input int v, input int hold = 1, input int gap = 1);
    par_input = v[15:0];
    next_val  = 1'b1;
    model_value(v);
    push_expected();
    repeat (hold) @(negedge clk);
    next_val  = 1'b0;
    par_input = 16'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests += 2;
    if (highest_val_sum !== 16'h0000) begin
      n_fail++;
      $display("FAIL %s_sum: got %h expected 0000", tag, highest_val_sum);
    end
    if (highest_val_index !== 8'h00) begin
      n_fail++;
      $display("FAIL %s_idx: got %0d expected 0", tag, highest_val_index);
    end
  endtask

  task automatic do_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_release");
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries never matched a DUT strobe", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    next_val  = 1'b0;
    par_input = 16'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("por");

    // Progress that a mid-run reset must discard.
    send(5000); send(0); send(7000);
    do_reset();

    // Reference sequence, 10000 left open.
    begin
      int ref_seq[$] = '{1000, 2000, 3000, 0, 4000, 0, 5000, 6000, 0,
                         7000, 8000, 9000, 0, 10000};
      foreach (ref_seq[k]) send(ref_seq[k]);
    end
    drain();

    // Held strobe: one value for five cycles of next_val.
    do_reset();
    send(100, 5); send(0);
    drain();

    // Tie and empty group.
    do_reset();
    begin
      int tie_seq[$] = '{500, 0, 0, 300, 200, 0};
      foreach (tie_seq[k]) send(tie_seq[k]);
    end
    drain();

    // Saturating sum, then a tie at the ceiling.
    do_reset();
    send(16'hFFF0); send(16'h0020); send(0); send(16'hFFFF); send(0);
    drain();

    // Index saturation: 300 groups of strictly increasing sum.
    do_reset();
    for (int g = 1; g <= 300; g++) begin
      send(g, 1, 1);
      send(0, 1, 1);
    end
    drain();

    // next_val already high when reset releases counts as a strobe.
    repeat (2) @(negedge clk);
    rst_n     = 1'b0;
    model_reset();
    next_val  = 1'b1;
    par_input = 16'd42;
    @(negedge clk);
    rst_n = 1'b1;
    model_value(42);
    push_expected();
    @(negedge clk);
    next_val = 1'b0;
    @(negedge clk);
    send(0);
    drain();

    // Randomized traffic with occasional resets.
    do_reset();
    n = 0;
    for (int t = 0; t < 1500; t++) begin
      int v;
      int r;
      r = $urandom_range(0, 99);
      if (r < 25)       v = 0;
      else if (r < 35)  v = $urandom_range(1, 65535);
      else if (r < 40)  v = $urandom_range(60000, 65535);
      else              v = $urandom_range(1, 3000);
      send(v, $urandom_range(1, 3), $urandom_range(1, 2));
      n++;
      if (n > 200 && $urandom_range(0, 99) < 2) begin
        drain();
        do_reset();
        n = 0;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
